// File: rtl/accel_bus_pkg.sv
// Shared types and constants for the accelerator register-bus model.
package accel_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int RDWR_RD      = 1;
  localparam int RDWR_WR      = 0;
  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;

  // Widened compare keeps the range check meaningful for any ADDR_W.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned num_regs);
    return (addr < num_regs);
  endfunction

endpackage

// File: rtl/accel_bus_model_if.sv
// CPU-to-accelerator register bus: CPU is the master, the accelerator model is the slave.
interface accel_bus_model_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              bus_en;
  logic              bus_start;
  logic [1:0]        bus_rdwr;
  logic [ADDR_W-1:0] bus_regaddr;
  logic [DATA_W-1:0] bus_data_in;
  logic [DATA_W-1:0] bus_data_out;
  logic              bus_data_oe;
  logic              bus_done;
  logic              busy;
  logic              err_sticky;

  modport master (
    output bus_en, bus_start, bus_rdwr, bus_regaddr, bus_data_in,
    input  bus_data_out, bus_data_oe, bus_done, busy, err_sticky
  );

  modport slave (
    input  bus_en, bus_start, bus_rdwr, bus_regaddr, bus_data_in,
    output bus_data_out, bus_data_oe, bus_done, busy, err_sticky
  );
endinterface

// File: rtl/accel_regfile.sv
// Accelerator register array: one write port, one registered read port, operand taps 0..2.
module accel_regfile
  import accel_bus_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] reg0_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;
  logic              w_ok_s, r_ok_s;
  logic [IDX_W-1:0]  widx_s, ridx_s;

  assign w_ok_s = addr_in_range(32'(waddr_i), NUM_REGS);
  assign r_ok_s = addr_in_range(32'(raddr_i), NUM_REGS);
  assign widx_s = waddr_i[IDX_W-1:0];
  assign ridx_s = raddr_i[IDX_W-1:0];

  // Out-of-range reads return zero; with no request the last data is held.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = r_ok_s ? regs_q[ridx_s] : '0;
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (we_i && w_ok_s) begin
        regs_q[widx_s] <= wdata_i;
      end
      rdata_q  <= rdata_d;
      rvalid_q <= re_i;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign reg0_o   = regs_q[0];
  assign reg1_o   = regs_q[1];
  assign reg2_o   = regs_q[2];

endmodule

// File: rtl/accel_bus_model.sv
// Cycle-accurate accelerator bus model: register file, start/done handshake, r7 = r0*r1 + r2.
// Define ACCEL_MOCK_STATS_EN to add the saturating op_count output.
module accel_bus_model
  import accel_bus_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = 3,
  parameter int DONE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  accel_bus_model_if.slave  bus
`ifdef ACCEL_MOCK_STATS_EN
  ,
  output logic [15:0]       op_count
`endif
);

  localparam int CNT_W = (DONE_LAT > 1) ? $clog2(DONE_LAT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, busy_q, err_q, err_d;
  logic              start_s, wr_s, rd_s, addr_ok_s;
  logic              cpu_we_s, res_we_s, we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s, result_s, rdata_s;
  logic [DATA_W-1:0] reg0_s, reg1_s, reg2_s;
  logic              rvalid_s;

  assign start_s   = bus.bus_en & bus.bus_start;
  assign wr_s      = bus.bus_en & bus.bus_rdwr[RDWR_WR];
  assign rd_s      = bus.bus_en & bus.bus_rdwr[RDWR_RD];
  assign addr_ok_s = addr_in_range(32'(bus.bus_regaddr), NUM_REGS);
  assign result_s  = reg0_s * reg1_s + reg2_s;

  // Handshake FSM; the result is committed on the edge that leaves BUSY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(DONE_LAT - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          res_we_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!start_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cpu_we_s = wr_s && (state_q == ST_IDLE) && addr_ok_s;
  assign we_s     = cpu_we_s | res_we_s;
  assign waddr_s  = res_we_s ? ADDR_W'(NUM_REGS - 1) : bus.bus_regaddr;
  assign wdata_s  = res_we_s ? result_s : bus.bus_data_in;
  assign err_d    = err_q
                  | (wr_s && ((state_q != ST_IDLE) || !addr_ok_s))
                  | (rd_s && !addr_ok_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == ST_DONE);
      busy_q  <= (state_d != ST_IDLE);
      err_q   <= err_d;
    end
  end

  accel_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we_s),
    .waddr_i  (waddr_s),
    .wdata_i  (wdata_s),
    .re_i     (rd_s),
    .raddr_i  (bus.bus_regaddr),
    .rdata_o  (rdata_s),
    .rvalid_o (rvalid_s),
    .reg0_o   (reg0_s),
    .reg1_o   (reg1_s),
    .reg2_o   (reg2_s)
  );

  assign bus.bus_data_out = rdata_s;
  assign bus.bus_data_oe  = rvalid_s;
  assign bus.bus_done     = done_q;
  assign bus.busy         = busy_q;
  assign bus.err_sticky   = err_q;

`ifdef ACCEL_MOCK_STATS_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_q <= 16'h0000;
    end else if (res_we_s && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_q <= op_cnt_q + 16'h0001;
    end
  end

  assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_accel_bus_model.sv
// Self-checking bench for accel_bus_model against a cycle-level reference model.
`timescale 1ns/1ps
module tb_accel_bus_model;
  import accel_bus_pkg::*;

  localparam int DW  = 16;
  localparam int NR  = 8;
  localparam int AW  = 4;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  accel_bus_model_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  accel_bus_model_if #(.DATA_W(DW), .ADDR_W(3))  bus2 ();

`ifdef ACCEL_MOCK_STATS_EN
  logic [15:0] op_count, op_count2;
`endif

  accel_bus_model #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .DONE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef ACCEL_MOCK_STATS_EN
    , .op_count(op_count)
`endif
  );

  accel_bus_model #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(3), .DONE_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst2), .bus(bus2)
`ifdef ACCEL_MOCK_STATS_EN
    , .op_count(op_count2)
`endif
  );

  // Reference model: op age counted in cycles since acceptance, -1 when none pending.
  logic [15:0] m_regs [NR];
  int          m_age;
  bit          m_done, m_err, m_oe;
  logic [15:0] m_rd;
  int          m_ops;
  int          n_checks, n_errors;

  function automatic bit m_busy();
    return (m_age >= 0) || m_done;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 16'h0000;
    m_age = -1; m_done = 1'b0; m_err = 1'b0; m_oe = 1'b0; m_rd = 16'h0000; m_ops = 0;
  endtask

  task automatic model_edge(input bit en, input bit start, input logic [1:0] rdwr,
                            input int addr, input logic [15:0] din);
    logic [15:0] nxt [NR];
    bit          idle;
    longint      prod;
    nxt  = m_regs;
    idle = (m_age < 0) && !m_done;
    if (en && rdwr[1]) begin
      m_oe = 1'b1;
      if (addr < NR) m_rd = m_regs[addr];
      else begin m_rd = 16'h0000; m_err = 1'b1; end
    end else begin
      m_oe = 1'b0;
    end
    if (en && rdwr[0]) begin
      if (idle && addr < NR) nxt[addr] = din;
      else m_err = 1'b1;
    end
    if (m_done) begin
      if (!(en && start)) m_done = 1'b0;
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age == LAT) begin
        prod = longint'(m_regs[0]) * longint'(m_regs[1]) + longint'(m_regs[2]);
        nxt[NR-1] = 16'(prod % 65536);
        m_age  = -1;
        m_done = 1'b1;
        if (m_ops < 65535) m_ops++;
      end
    end else if (en && start) begin
      m_age = 0;
    end
    m_regs = nxt;
  endtask

  task automatic step(input bit en, input bit start, input logic [1:0] rdwr,
                      input int addr, input logic [15:0] din, input bit r);
    rst             = r;
    bus.bus_en      = en;
    bus.bus_start   = start;
    bus.bus_rdwr    = rdwr;
    bus.bus_regaddr = AW'(addr);
    bus.bus_data_in = din;
    @(posedge clk);
    if (r) model_reset();
    else model_edge(en, start, rdwr, addr, din);
    #1;
  endtask

  task automatic idle();                                   step(1'b0, 1'b0, 2'b00, 0, 16'h0000, 1'b0); endtask
  task automatic do_reset();                               step(1'b0, 1'b0, 2'b00, 0, 16'h0000, 1'b1); endtask
  task automatic wr(input int a, input logic [15:0] d);    step(1'b1, 1'b0, 2'b01, a, d, 1'b0);        endtask
  task automatic rd(input int a);                          step(1'b1, 1'b0, 2'b10, a, 16'h0000, 1'b0); endtask
  task automatic start_op(input bit hold);                 step(1'b1, hold, 2'b00, 0, 16'h0000, 1'b0); endtask

  task automatic test_reset();
    do_reset(); do_reset();
    n_checks++; if (bus.busy !== 1'b0)         begin n_errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_checks++; if (bus.bus_done !== 1'b0)     begin n_errors++; $display("FAIL reset_done: got %0b want 0", bus.bus_done); end
    n_checks++; if (bus.bus_data_oe !== 1'b0)  begin n_errors++; $display("FAIL reset_oe: got %0b want 0", bus.bus_data_oe); end
    n_checks++; if (bus.bus_data_out !== 16'h0) begin n_errors++; $display("FAIL reset_data: got %0h want 0", bus.bus_data_out); end
    for (int a = 0; a < NR; a++) begin
      rd(a);
      n_checks++; if (bus.bus_data_oe !== 1'b1 || bus.bus_data_out !== 16'h0000) begin
        n_errors++; $display("FAIL reset_read%0d: got oe=%0b data=%0h want oe=1 data=0", a, bus.bus_data_oe, bus.bus_data_out);
      end
    end
    idle();
    n_checks++; if (bus.bus_data_oe !== 1'b0)  begin n_errors++; $display("FAIL oe_pulse: got %0b want 0", bus.bus_data_oe); end
    n_checks++; if (bus.err_sticky !== 1'b0)   begin n_errors++; $display("FAIL reset_err: got %0b want 0", bus.err_sticky); end
  endtask

  task automatic test_compute();
    int lat;
    wr(0, 16'd3); wr(1, 16'd5); wr(2, 16'd7);
    start_op(1'b1);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      start_op(1'b1);
      if (bus.bus_done === 1'b1) lat = i;
    end
    n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL done_latency: got %0d want %0d", lat, LAT); end
    start_op(1'b1); start_op(1'b1);
    n_checks++; if (bus.bus_done !== 1'b1 || bus.busy !== 1'b1) begin
      n_errors++; $display("FAIL done_hold: got done=%0b busy=%0b want 1 1", bus.bus_done, bus.busy);
    end
    start_op(1'b0);
    n_checks++; if (bus.bus_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL done_drop: got done=%0b busy=%0b want 0 0", bus.bus_done, bus.busy);
    end
    rd(7);
    n_checks++; if (bus.bus_data_out !== 16'h0016) begin n_errors++; $display("FAIL result_3x5p7: got %0h want 0016", bus.bus_data_out); end
  endtask

  task automatic test_truncate();
    bit seen;
    wr(0, 16'h0100); wr(1, 16'h0100); wr(2, 16'h0001);
    start_op(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle();
      if (bus.bus_done === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL trunc_done: got no done want done"); end
    idle();
    rd(7);
    n_checks++; if (bus.bus_data_out !== 16'h0001) begin n_errors++; $display("FAIL result_trunc: got %0h want 0001", bus.bus_data_out); end
`ifdef ACCEL_MOCK_STATS_EN
    n_checks++; if (op_count !== 16'(m_ops)) begin n_errors++; $display("FAIL op_count: got %0d want %0d", op_count, m_ops); end
`endif
  endtask

  task automatic test_errors();
    do_reset();
    wr(1, 16'h1234);
    start_op(1'b1);
    wr(1, 16'hAAAA);
    n_checks++; if (bus.err_sticky !== 1'b1) begin n_errors++; $display("FAIL busy_write_err: got %0b want 1", bus.err_sticky); end
    for (int i = 0; i < LAT + 2; i++) idle();
    rd(1);
    n_checks++; if (bus.bus_data_out !== 16'h1234) begin n_errors++; $display("FAIL busy_write_drop: got %0h want 1234", bus.bus_data_out); end
    do_reset();
    wr(3, 16'h5A5A); rd(3);
    n_checks++; if (bus.bus_data_out !== 16'h5A5A || bus.err_sticky !== 1'b0) begin
      n_errors++; $display("FAIL rd3: got data=%0h err=%0b want 5a5a 0", bus.bus_data_out, bus.err_sticky);
    end
    rd(9);
    n_checks++; if (bus.bus_data_out !== 16'h0000 || bus.bus_data_oe !== 1'b1 || bus.err_sticky !== 1'b1) begin
      n_errors++; $display("FAIL rd_oob: got data=%0h oe=%0b err=%0b want 0 1 1", bus.bus_data_out, bus.bus_data_oe, bus.err_sticky);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done, nonzero;
    wr(0, 16'd2); wr(1, 16'd2); wr(2, 16'd2);
    start_op(1'b1);
    idle();
    do_reset();
    n_checks++; if (bus.busy !== 1'b0 || bus.bus_done !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset: got busy=%0b done=%0b want 0 0", bus.busy, bus.bus_done);
    end
    saw_done = 1'b0; nonzero = 1'b0;
    for (int a = 0; a < NR; a++) begin
      rd(a);
      if (bus.bus_done === 1'b1) saw_done = 1'b1;
      if (bus.bus_data_out !== 16'h0000) nonzero = 1'b1;
    end
    n_checks++; if (nonzero) begin n_errors++; $display("FAIL mid_reset_regs: got nonzero want all 0"); end
    n_checks++; if (saw_done) begin n_errors++; $display("FAIL mid_reset_done: got done pulse want none"); end
  endtask

  task automatic test_rdwr_same();
    wr(2, 16'h1111);
    step(1'b1, 1'b0, 2'b11, 2, 16'h2222, 1'b0);
    n_checks++; if (bus.bus_data_out !== 16'h1111) begin n_errors++; $display("FAIL rdwr_old: got %0h want 1111", bus.bus_data_out); end
    rd(2);
    n_checks++; if (bus.bus_data_out !== 16'h2222) begin n_errors++; $display("FAIL rdwr_new: got %0h want 2222", bus.bus_data_out); end
  endtask

  task automatic test_lat1();
    rst2 = 1'b1; bus2.bus_en = 1'b0; bus2.bus_start = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b0; bus2.bus_en = 1'b1; bus2.bus_start = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus2.busy !== 1'b1 || bus2.bus_done !== 1'b0) begin
      n_errors++; $display("FAIL lat1_accept: got busy=%0b done=%0b want 1 0", bus2.busy, bus2.bus_done);
    end
    bus2.bus_start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus2.bus_done !== 1'b1) begin n_errors++; $display("FAIL lat1_done: got %0b want 1", bus2.bus_done); end
    @(posedge clk); #1;
    n_checks++; if (bus2.bus_done !== 1'b0 || bus2.busy !== 1'b0) begin
      n_errors++; $display("FAIL lat1_drop: got done=%0b busy=%0b want 0 0", bus2.bus_done, bus2.busy);
    end
  endtask

  task automatic test_random();
    bit          en, st, r;
    logic [1:0]  rw;
    int          a;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(99) == 0);
      en = ($urandom_range(7) != 0);
      st = ($urandom_range(3) == 0);
      rw = 2'($urandom_range(3));
      a  = ($urandom_range(7) == 0) ? int'($urandom_range(15, 8)) : int'($urandom_range(7));
      step(en, st, rw, a, 16'($urandom), r);
      n_checks++; if (bus.busy !== m_busy())       begin n_errors++; $display("FAIL rnd_busy@%0d: got %0b want %0b", i, bus.busy, m_busy()); end
      n_checks++; if (bus.bus_done !== m_done)     begin n_errors++; $display("FAIL rnd_done@%0d: got %0b want %0b", i, bus.bus_done, m_done); end
      n_checks++; if (bus.bus_data_oe !== m_oe)    begin n_errors++; $display("FAIL rnd_oe@%0d: got %0b want %0b", i, bus.bus_data_oe, m_oe); end
      n_checks++; if (bus.bus_data_out !== m_rd)   begin n_errors++; $display("FAIL rnd_data@%0d: got %0h want %0h", i, bus.bus_data_out, m_rd); end
      n_checks++; if (bus.err_sticky !== m_err)    begin n_errors++; $display("FAIL rnd_err@%0d: got %0b want %0b", i, bus.err_sticky, m_err); end
`ifdef ACCEL_MOCK_STATS_EN
      n_checks++; if (op_count !== 16'(m_ops))     begin n_errors++; $display("FAIL rnd_ops@%0d: got %0d want %0d", i, op_count, m_ops); end
`endif
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; rst2 = 1'b1;
    bus.bus_en = 1'b0; bus.bus_start = 1'b0; bus.bus_rdwr = 2'b00;
    bus.bus_regaddr = '0; bus.bus_data_in = 16'h0000;
    bus2.bus_en = 1'b0; bus2.bus_start = 1'b0; bus2.bus_rdwr = 2'b00;
    bus2.bus_regaddr = '0; bus2.bus_data_in = 16'h0000;
    model_reset();
    test_reset();
    test_compute();
    test_truncate();
    test_errors();
    test_reset_mid();
    test_rdwr_same();
    test_lat1();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
